// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared types and helpers for the systolic array slice.
package sys_array_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, STREAM} drain_state_t;

   function automatic int idx_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/sys_rowcol_counter.sv
// sys_rowcol_counter: row-major (row, col) index walker with clear, enable and last flag.
module sys_rowcol_counter import sys_array_pkg::*; #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   localparam int RW = idx_w(ROWS),
   localparam int CW = idx_w(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [RW-1:0] row_o,
   output logic [CW-1:0] col_o,
   output logic          last_o
);
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          wrap;
   assign wrap   = col_q == CW'(COLS - 1);
   assign last_o = wrap && row_q == RW'(ROWS - 1);
   assign row_o  = row_q;
   assign col_o  = col_q;
   always_comb begin
      col_d = wrap ? '0 : col_q + 1'b1;
      row_d = last_o ? '0 : wrap ? row_q + 1'b1 : row_q;
   end
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (en_i) begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
endmodule

// File: rtl/sys_result_drain.sv
// sys_result_drain: snapshots the systolic result matrix after a settle delay
// and streams it row-major over valid/ready.
module sys_result_drain import sys_array_pkg::*; #(
   parameter int n             = 8,
   parameter int matrix_size   = 4,
   parameter int settle_cycles = 10,
   localparam int IW = idx_w(matrix_size)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [2*n-1:0] dataC_in [matrix_size][matrix_size],
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [2*n-1:0] out_data,
   output logic [IW-1:0]       out_row,
   output logic [IW-1:0]       out_col,
   output logic                out_last,
   output logic                done
);
   typedef logic signed [2*n-1:0] acc_t;
   localparam int SW = idx_w(settle_cycles + 1);

   drain_state_t state_q;
   logic [SW-1:0] cnt_q;
   logic          done_q;
   logic          capture;
   acc_t          buf_q [matrix_size][matrix_size];

   // Capture happens either straight from IDLE (zero settle) or when the settle count expires.
   assign capture = (state_q == IDLE && start && settle_cycles == 0) ||
                    (state_q == WAIT && cnt_q == '0);
   assign busy      = state_q != IDLE;
   assign out_valid = state_q == STREAM;
   assign done      = done_q;
   assign out_data  = buf_q[out_row][out_col];

   sys_rowcol_counter #(.ROWS(matrix_size), .COLS(matrix_size)) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (capture),
      .en_i   (out_valid && out_ready),
      .row_o  (out_row),
      .col_o  (out_col),
      .last_o (out_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         buf_q   <= '{default: '0};
      end else begin
         done_q <= 1'b0;
         if (capture) buf_q <= dataC_in;
         case (state_q)
            IDLE: if (start) begin
               state_q <= (settle_cycles == 0) ? STREAM : WAIT;
               cnt_q   <= SW'(settle_cycles > 0 ? settle_cycles - 1 : 0);
            end
            WAIT: if (capture) state_q <= STREAM;
                  else cnt_q <= cnt_q - 1'b1;
            STREAM: if (out_ready && out_last) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sys_result_drain.sv
// tb_sys_result_drain: directed and table-driven checks of the result drain.
module tb_sys_result_drain;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic signed [15:0] dataC [4][4];
   logic busy, out_valid, out_last, done;
   logic signed [15:0] out_data;
   logic [1:0] out_row, out_col;

   logic start1 = 1'b0, ready1 = 1'b0;
   logic signed [15:0] dataC1 [1][1];
   logic busy1, valid1, last1, done1;
   logic signed [15:0] data1;
   logic [0:0] row1, col1;

   int A [4][4] = '{'{-1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, -11, 12}, '{13, 14, 15, 15}};
   int B [4][4] = '{'{1, 1, 1, 1}, '{2, 2, -2, 2}, '{3, 3, 3, 3}, '{4, 4, 4, 4}};
   int C [4][4];
   int n_chk = 0, n_fail = 0;

   typedef struct {
      int cyc; int busy; int valid; int last; int done; int row; int col; int data;
   } vec_t;
   vec_t tv [9];

   sys_result_drain #(.n(8), .matrix_size(4), .settle_cycles(10)) dut (
      .clk(clk), .rst(rst), .start(start), .dataC_in(dataC), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
   );

   sys_result_drain #(.n(8), .matrix_size(1), .settle_cycles(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .dataC_in(dataC1), .busy(busy1),
      .out_valid(valid1), .out_ready(ready1), .out_data(data1),
      .out_row(row1), .out_col(col1), .out_last(last1), .done(done1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic drain(input bit rnd, input bit clobber, input bit poke);
      int e = 0;
      int hd, hr, hc;
      bit stall;
      for (int w = 0; w < 20 && !out_valid; w++) step();
      check("drain_valid", out_valid, 1);
      if (clobber) foreach (dataC[i, j]) dataC[i][j] = -16'sd1;
      for (int c = 0; c < 300 && e < 16 && out_valid; c++) begin
         out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
         start = poke && (e == 5 || e == 15);
         stall = !out_ready;
         hd = out_data; hr = out_row; hc = out_col;
         if (out_ready) begin
            check($sformatf("data[%0d]", e), out_data, C[e/4][e%4]);
            check($sformatf("row[%0d]", e), out_row, e / 4);
            check($sformatf("col[%0d]", e), out_col, e % 4);
            check($sformatf("last[%0d]", e), out_last, e == 15);
            e++;
         end
         step();
         if (stall) begin
            check("hold_data", out_data, hd);
            check("hold_row", out_row, hr);
            check("hold_col", out_col, hc);
            check("hold_valid", out_valid, 1);
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      check("transfers", e, 16);
      check("done_hi", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", out_valid, 0);
      step();
      check("done_pulse", done, 0);
      if (clobber) foreach (dataC[i, j]) dataC[i][j] = 16'(C[i][j]);
   endtask

   initial begin
      int k, seen;
      foreach (C[i, j]) begin
         C[i][j] = 0;
         for (int p = 0; p < 4; p++) C[i][j] += A[i][p] * B[p][j];
         dataC[i][j] = 16'(C[i][j]);
      end
      dataC1[0][0] = -16'sd5;
      tv[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
      tv[1] = '{9, 1, 0, 0, 0, 0, 0, 0};
      tv[2] = '{10, 1, 1, 0, 0, 0, 0, 28};
      tv[3] = '{12, 1, 1, 0, 0, 0, 2, 20};
      tv[4] = '{18, 1, 1, 0, 0, 2, 0, 44};
      tv[5] = '{20, 1, 1, 0, 0, 2, 2, 4};
      tv[6] = '{25, 1, 1, 1, 0, 3, 3, 146};
      tv[7] = '{26, 0, 0, 0, 1, 0, 0, 0};
      tv[8] = '{27, 0, 0, 0, 0, 0, 0, 0};

      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_row", out_row, 0);
      check("rst_col", out_col, 0);
      check("rst_data", out_data, 0);
      check("rst_valid1", valid1, 0);
      rst = 1'b0;
      step();

      // Full-rate drain checked against the cycle table
      out_ready = 1'b1;
      kick();
      k = 0;
      for (int i = 0; i < 9; i++) begin
         while (k < tv[i].cyc) begin
            step();
            k++;
         end
         check($sformatf("t%0d_busy", k), busy, tv[i].busy);
         check($sformatf("t%0d_valid", k), out_valid, tv[i].valid);
         check($sformatf("t%0d_last", k), out_last, tv[i].last);
         check($sformatf("t%0d_done", k), done, tv[i].done);
         if (tv[i].valid != 0) begin
            check($sformatf("t%0d_row", k), out_row, tv[i].row);
            check($sformatf("t%0d_col", k), out_col, tv[i].col);
            check($sformatf("t%0d_data", k), out_data, tv[i].data);
         end
      end
      step();

      kick();
      drain(1'b1, 1'b0, 1'b0);
      kick();
      drain(1'b0, 1'b1, 1'b0);

      // Start pokes during WAIT, mid-STREAM and on the final transfer edge
      kick();
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      drain(1'b0, 1'b0, 1'b1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (busy) seen = 1;
         step();
      end
      check("no_second_drain", seen, 0);

      // Reset in the middle of streaming, then a clean restart
      kick();
      for (int w = 0; w < 20 && !out_valid; w++) step();
      for (int i = 0; i < 7; i++) step();
      check("pre_rst_row", out_row, 1);
      check("pre_rst_col", out_col, 3);
      check("pre_rst_data", out_data, C[1][3]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_row", out_row, 0);
      check("abort_col", out_col, 0);
      check("abort_done", done, 0);
      check("abort_data", out_data, 0);
      step();
      check("abort_done2", done, 0);
      kick();
      drain(1'b0, 1'b0, 1'b0);

      // Single-element matrix with zero settle time
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("m1_valid", valid1, 1);
      check("m1_last", last1, 1);
      check("m1_data", data1, -5);
      check("m1_busy", busy1, 1);
      step();
      check("m1_hold_valid", valid1, 1);
      check("m1_hold_data", data1, -5);
      ready1 = 1'b1;
      step();
      ready1 = 1'b0;
      check("m1_done", done1, 1);
      check("m1_valid_off", valid1, 0);
      check("m1_busy_off", busy1, 0);
      step();
      check("m1_done_pulse", done1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sys_result_drain.md
# sys_result_drain

Result-side drain for the parametrized systolic array. On a `start` pulse it waits a fixed settle time for `sysArray` to finish accumulating, then snapshots the full `dataC` matrix. It streams the snapshot out one element per transfer, in row-major order, over a valid/ready interface. It sits between `sysArray.dataC_out` and any downstream consumer (UART/bus bridge, checker), freeing the array for the next operand load once the snapshot is taken.

## Interface
- `n`, 8, operand width; result elements are signed 2*n bits
- `matrix_size`, 4, square matrix dimension M
- `settle_cycles`, 10, cycles from accepted `start` to capture; 0 allowed
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request capture+drain; honored only in IDLE
- `dataC_in` in signed [2n-1:0] x [M][M]: result matrix from `sysArray`
- `busy` out 1: high in WAIT or STREAM
- `out_valid` out 1: element available
- `out_ready` in 1: consumer accepts
- `out_data` out signed 2n: current element C[row][col]
- `out_row`, `out_col` out IW = max(1, $clog2(M)) each: index of `out_data`
- `out_last` out 1: high with element (M-1, M-1)
- `done` out 1: one-cycle pulse after final transfer

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE:
  - `start`=1 with `settle_cycles`>0: WAIT, counter loads `settle_cycles`-1.
  - `start`=1 with `settle_cycles`=0: capture `dataC_in` at the same edge, go to STREAM.
- WAIT: counter decrements each edge. At the edge where counter==0, capture all M*M elements into the internal buffer, reset indices to (0,0) and go to STREAM.
- STREAM: `out_valid`=1. A transfer happens on any edge with `out_valid`&&`out_ready`.
  - On a transfer, `out_col` increments. At `out_col`==M-1 it wraps to 0 and `out_row` increments.
  - A transfer while `out_last`=1 returns the block to IDLE and asserts `done` for the next cycle.
- `start` in WAIT/STREAM is ignored (no queuing). `start` on the same edge as the final transfer is also ignored; the block is in IDLE only from the following cycle.
- `dataC_in` is sampled only at capture. Later changes do not affect the streamed data.
- Data, indices and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_ready` outside STREAM has no effect.
- No arithmetic: elements pass through bit-exact, sign preserved.

## Timing
- Reset values: state IDLE, `busy`=0, `out_valid`=0, `out_last`=0, `done`=0, `out_row`=`out_col`=0, buffer all zeros (so `out_data`=0).
- `rst` in any state (mid-WAIT or mid-STREAM) aborts at that edge and restores reset values. No `done` is generated. Reset wins over a simultaneous `start` or transfer.
- `start` sampled at edge t: `busy` goes high after edge t, and `out_valid` goes high after edge t+`settle_cycles`.
- Streaming throughput: one element per cycle with `out_ready` held high. M*M transfers are needed, so `busy` stays high `settle_cycles`+M*M cycles minimum.
- `done` is high for exactly the one cycle after the last-transfer edge. `busy` is low in that same cycle.
- All outputs are registered or driven directly from registered state and buffer. No combinational path from `out_ready` to `out_valid`.

## Structure
- Shared package `sys_array_pkg`:
  - state enum `drain_state_t` {IDLE, WAIT, STREAM}
  - index width function `idx_w(M)`
  - result element typedef `acc_t` = logic signed [2n-1:0], parametrized via package parameter or local typedef
- One sub-module is natural: `sys_rowcol_counter`, a row/col index counter with clear, enable, wrap and last-flag outputs. It is reusable later for the operand-loader side.

## Test plan
- Load the 4x4 product (A rows {-1,2,3,4},{5,6,7,8},{9,10,-11,12},{13,14,15,15}; B rows {1,1,1,1},{2,2,-2,2},{3,3,3,3},{4,4,4,4}) and pulse `start` with `out_ready`=1. Required response: first valid exactly 10 cycles later, C[0][0]=28, C[0][2]=20, C[2][0]=44, C[2][2]=4, C[3][3]=146 with `out_last`, `done` one cycle after, 16 transfers total.
- Random `out_ready` backpressure: data, row and col hold while stalled, and the element sequence is identical to the first test.
- Change `dataC_in` to all -1 after capture: the stream still carries the captured values.
- `start` pulsed during WAIT and during STREAM: ignored, and exactly one drain of 16 elements occurs.
- `rst` asserted mid-STREAM at element 7: next cycle `out_valid`=0, `busy`=0, indices 0, no `done`; a new `start` then restarts cleanly from C[0][0].
- `settle_cycles`=0 with `matrix_size`=1: `out_valid` high the cycle after `start`, `out_last`=1 on the sole element, `done` after one transfer.
